// File: rtl/queue_counter.sv
// queue_counter
//   Front end of the queue manager. Synchronises and debounces the entry and
//   exit sensors, keeps a saturating 0..7 count of waiting customers and holds
//   the active teller count. {pcount, tcount} addresses the waiting-time ROM.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   sens_in     raw entry sensor (asynchronous)
//   sens_out    raw exit/served sensor (asynchronous)
//   tellers     requested number of open tellers
//   tellers_ld  synchronous strobe, loads tellers into tcount
//   pcount      people waiting, 0..7
//   tcount      active tellers, 0..3
//   full        pcount == 7
//   empty       pcount == 0
//   err_ovf     one-cycle pulse, entry rejected because queue is full
//   err_unf     one-cycle pulse, exit rejected because queue is empty

module queue_counter #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sens_in,
    input  logic       sens_out,
    input  logic [1:0] tellers,
    input  logic       tellers_ld,
    output logic [2:0] pcount,
    output logic [1:0] tcount,
    output logic       full,
    output logic       empty,
    output logic       err_ovf,
    output logic       err_unf
);

    localparam logic [3:0] DcMax = 4'(DEB_CYCLES - 1);

    // Index 0 = entry sensor, index 1 = exit sensor.
    logic [1:0] raw;
    logic [1:0] s1_q, s2_q;
    logic [1:0] deb_q, deb_d;
    logic [3:0] dc_q [2];
    logic [3:0] dc_d [2];
    logic [1:0] ev;

    logic [2:0] pcount_q, pcount_d;
    logic [1:0] tcount_q, tcount_d;
    logic       err_ovf_q, err_ovf_d;
    logic       err_unf_q, err_unf_d;

    assign raw = {sens_out, sens_in};

    // Debounce: deb follows s2 only after DEB_CYCLES consecutive differing edges.
    always_comb begin
        deb_d = deb_q;
        ev    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            dc_d[i] = 4'd0;
            if (s2_q[i] != deb_q[i]) begin
                if (dc_q[i] == DcMax) begin
                    deb_d[i] = s2_q[i];
                    // Only a rising debounced level is a customer event.
                    ev[i]    = s2_q[i];
                end else begin
                    dc_d[i] = dc_q[i] + 4'd1;
                end
            end
        end
    end

    // Saturating count; simultaneous entry and exit cancel with no error.
    always_comb begin
        pcount_d  = pcount_q;
        err_ovf_d = 1'b0;
        err_unf_d = 1'b0;
        if (ev[0] && !ev[1]) begin
            if (pcount_q != 3'd7) begin
                pcount_d = pcount_q + 3'd1;
            end else begin
                err_ovf_d = 1'b1;
            end
        end else if (ev[1] && !ev[0]) begin
            if (pcount_q != 3'd0) begin
                pcount_d = pcount_q - 3'd1;
            end else begin
                err_unf_d = 1'b1;
            end
        end
    end

    always_comb begin
        tcount_d = tcount_q;
        if (tellers_ld) begin
            tcount_d = tellers;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 2'b00;
            s2_q      <= 2'b00;
            deb_q     <= 2'b00;
            dc_q[0]   <= 4'd0;
            dc_q[1]   <= 4'd0;
            pcount_q  <= 3'd0;
            tcount_q  <= 2'd0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            deb_q     <= deb_d;
            dc_q[0]   <= dc_d[0];
            dc_q[1]   <= dc_d[1];
            pcount_q  <= pcount_d;
            tcount_q  <= tcount_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    assign pcount  = pcount_q;
    assign tcount  = tcount_q;
    assign full    = (pcount_q == 3'd7);
    assign empty   = (pcount_q == 3'd0);
    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;

endmodule

// File: doc/queue_counter.md
Name: queue_counter

Overview:
Front end of the queue manager. Tracks how many customers are waiting from two door/desk sensors, and holds the active teller count. Drives the pcount/tcount lookup address of the waiting-time ROM; pcount and tcount go straight to that ROM with no extra logic between.
Fully synchronous except reset. Includes sensor synchronisers, debouncers, saturating up/down count, and status/error flags.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles required before a synchronised sensor level is accepted (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
sens_in  input  1  raw entry sensor, asynchronous, high while a customer crosses it
sens_out  input  1  raw exit/served sensor, asynchronous, high while a customer crosses it
tellers  input  2  number of open tellers requested by the operator panel
tellers_ld  input  1  synchronous strobe; loads tellers into tcount
pcount  output  3  people waiting, 0..7; ROM address high bits
tcount  output  2  active tellers, 0..3; ROM address low bits
full  output  1  high when pcount==7
empty  output  1  high when pcount==0
err_ovf  output  1  one-cycle pulse: entry event rejected because queue is full
err_unf  output  1  one-cycle pulse: exit event rejected because queue is empty

Behaviour:
- Reset (rst_n low, asynchronous): clear all of the following:
  - synchroniser flops, debounced levels, debounce counters
  - pcount=0, tcount=0, err_ovf=0, err_unf=0
  - full=0, empty=1
- Reset asserted mid-operation aborts any pending debounce immediately.
- Synchroniser: each sensor passes through 2 flops (s1, s2).
- Debouncer, per sensor, holds a debounced level deb and a counter dc (4 bits):
  - Each edge with s2==deb: dc<=0.
  - Each edge with s2!=deb and dc<DEB_CYCLES-1: dc<=dc+1.
  - Each edge with s2!=deb and dc==DEB_CYCLES-1: deb<=s2, dc<=0.
- Event definition: an event is a deb 0->1 transition, one per customer. A deb 1->0 transition generates nothing.
- Latency: raw input high and stable from rising edge 0 (sampled into s1) → deb rises and pcount updates at edge DEB_CYCLES+1.
- Any glitch shorter than DEB_CYCLES cycles after synchronisation produces no event.
- Count update, on the edge at which an event occurs:
  - Entry only: pcount+1 if pcount<7; otherwise pcount unchanged and err_ovf=1 for that cycle.
  - Exit only: pcount-1 if pcount>0; otherwise pcount unchanged and err_unf=1 for that cycle.
  - Entry and exit on the same edge: pcount unchanged, no error pulses, even when full or empty.
- Count rules: no wrap-around; saturate at 0 and 7.
- Flags: err_ovf and err_unf are registered and return to 0 the next cycle unless re-triggered.
- full and empty are decoded from the pcount register. They are glitch-free and change on the same edge as pcount.
- tcount: tcount<=tellers on any edge with tellers_ld=1; otherwise it holds. tcount is independent of sensor events.
- Reset release with a sensor held high: deb starts at 0, so one event is counted at edge DEB_CYCLES+1 after release (exit with pcount=0 gives err_unf).
- No other state machine: the debouncers are the only sequential control. The count logic is a pure function of the two event strobes and pcount.

Test Plan:
- Reset: rst_n low mid-count with pcount=5 → asynchronously pcount=0, tcount=0, empty=1, full=0, errors 0. Release with sensors low → all hold.
- Latency/glitch (DEB_CYCLES=4): sens_in high for 3 cycles → pcount stays 0. sens_in high held from edge 0 → pcount=1 at edge 5, then no further change while held. Release and re-assert → pcount=2.
- Saturation high: 8 clean entry pulses from empty → pcount=7 and full=1 after the 7th. The 8th gives err_ovf=1 for exactly one cycle and pcount stays 7.
- Underflow: exit pulse at pcount=0 → err_unf single-cycle pulse, pcount=0, empty stays 1. Then 3 entries and 2 exits → pcount=1.
- Simultaneous events: sens_in and sens_out rising on the same cycle:
  - at pcount=3 → pcount stays 3
  - at pcount=7 → stays 7, no err_ovf
  - at pcount=0 → stays 0, no err_unf
- Teller load: tellers=2'b10 with tellers_ld high one cycle → tcount=2 next edge. tellers changed to 2'b11 without strobe → tcount stays 2. {pcount,tcount} with pcount=4 gives address 5'b10010.
